// File: rtl/display_pkg.sv
// Shared types and default timing constants for the dual-digit display multiplexer.
package display_pkg;

    typedef enum logic [1:0] {BLANK1, SHOW1, BLANK2, SHOW2} mux_state_t;

    // 48 MHz clock: 100000 cycles per slot gives 240 Hz per digit.
    localparam int DISP_DIV   = 100000;
    localparam int DISP_BLANK = 1000;

endpackage

// File: rtl/display_mux_synchronizer.sv
// Parameterized-width two-flop synchronizer for slow asynchronous inputs such as DIP switches.
module synchronizer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/display_mux.sv
// Time-multiplexes two synchronized switch nibbles onto one seven-segment decoder,
// with a blanking interval at the start of each digit slot to prevent ghosting.
module display_mux
    import display_pkg::*;
#(
    parameter int DIV   = DISP_DIV,
    parameter int BLANK = DISP_BLANK
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] switch1,
    input  logic [3:0] switch2,
    output logic [3:0] digit,
    output logic       anode1_n,
    output logic       anode2_n
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST       = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK_LAST = CW'(BLANK - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("display_mux: DIV must be at least 2");
        end
        if (BLANK < 1 || BLANK >= DIV) begin : g_blank_check
            $error("display_mux: BLANK must satisfy 1 <= BLANK < DIV");
        end
    endgenerate

    logic [3:0]    sw1_sync;
    logic [3:0]    sw2_sync;
    mux_state_t    state;
    mux_state_t    state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    synchronizer #(.WIDTH(4)) u_sync1 (.clk(clk), .reset(reset), .d(switch1), .q(sw1_sync));
    synchronizer #(.WIDTH(4)) u_sync2 (.clk(clk), .reset(reset), .d(switch2), .q(sw2_sync));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BLANK1;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
        unique case (state)
            BLANK1:  if (cnt == CNT_BLANK_LAST) state_next = SHOW1;
            SHOW1:   if (cnt == CNT_LAST)       state_next = BLANK2;
            BLANK2:  if (cnt == CNT_BLANK_LAST) state_next = SHOW2;
            SHOW2:   if (cnt == CNT_LAST)       state_next = BLANK1;
            default: state_next = BLANK1;
        endcase
    end

    // Outputs are registered from the next state so the pins come straight off flops;
    // the digit is latched only on slot entry so it never changes while lit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            digit    <= 4'h0;
            anode1_n <= 1'b1;
            anode2_n <= 1'b1;
        end else begin
            cnt      <= cnt_next;
            anode1_n <= (state_next != SHOW1);
            anode2_n <= (state_next != SHOW2);
            if (state == SHOW2 && state_next == BLANK1) begin
                digit <= sw1_sync;
            end else if (state == SHOW1 && state_next == BLANK2) begin
                digit <= sw2_sync;
            end
        end
    end

endmodule

// File: tb/tb_display_mux.sv
// Scoreboard bench for display_mux: an edge-indexed reference model predicts outputs,
// a negedge monitor compares them, plus directed checks of slot capture and async reset.
module tb_display_mux;

    localparam int DIV      = 10;
    localparam int BLANK    = 2;
    localparam int SHOW_LEN = DIV - BLANK;

    typedef struct {
        logic       a1;
        logic       a2;
        logic [3:0] d;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] switch1 = 4'h0;
    logic [3:0] switch2 = 4'h0;
    logic [3:0] digit;
    logic       anode1_n;
    logic       anode2_n;

    int checks = 0;
    int errors = 0;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n = 0;
    logic [3:0] h1[$];
    logic [3:0] h2[$];
    int         run1 = 0;
    int         run2 = 0;

    always #5 clk = ~clk;

    display_mux #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk     (clk),
        .reset   (reset),
        .switch1 (switch1),
        .switch2 (switch2),
        .digit   (digit),
        .anode1_n(anode1_n),
        .anode2_n(anode2_n)
    );

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, got, want, $time);
        end
    endtask

    // Expected outputs after edge e (counted from reset release), straight from the
    // slot arithmetic: slot = floor(e/DIV) parity, position = e mod DIV.
    // A switch sampled at edge k reaches the capture point at edge k+2.
    function automatic exp_t predict(int e);
        exp_t r;
        int   pos   = e % DIV;
        bit   slot1 = ((e / DIV) % 2) == 0;
        bit   show  = pos >= BLANK;
        int   c     = (e / DIV) * DIV;
        r.a1 = !(slot1 && show);
        r.a2 = !(!slot1 && show);
        if (c == 0)                  r.d = 4'h0;
        else if (((c / DIV) % 2) == 0) r.d = h1[c-2];
        else                         r.d = h2[c-2];
        return r;
    endfunction

    // Reference model: h1/h2[k] hold switch values seen at edge k; index 0 is the reset state.
    always @(posedge clk) begin
        if (reset) begin
            n  = 0;
            h1 = {4'h0};
            h2 = {4'h0};
            sb.push_back('{1'b1, 1'b1, 4'h0});
        end else begin
            n++;
            h1.push_back(switch1);
            h2.push_back(switch2);
            sb.push_back(predict(n));
        end
    end

    // Monitor: compares away from the active edge; reset is asynchronous and dominates.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            if (reset) mon_e = '{1'b1, 1'b1, 4'h0};
            check("anode1_n", {7'd0, anode1_n}, {7'd0, mon_e.a1});
            check("anode2_n", {7'd0, anode2_n}, {7'd0, mon_e.a2});
            check("digit", {4'd0, digit}, {4'd0, mon_e.d});
            check("anodes_exclusive", {7'd0, anode1_n | anode2_n}, 8'd1);
            if (reset) begin
                run1 = 0;
                run2 = 0;
            end else begin
                if (anode1_n === 1'b0) run1++;
                else if (run1 > 0) begin
                    check("show1_length", 8'(run1), 8'(SHOW_LEN));
                    run1 = 0;
                end
                if (anode2_n === 1'b0) run2++;
                else if (run2 > 0) begin
                    check("show2_length", 8'(run2), 8'(SHOW_LEN));
                    run2 = 0;
                end
            end
        end
    end

    task automatic edges(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with switches set: outputs must stay blank and zero.
        reset   = 1'b1;
        switch1 = 4'hA;
        switch2 = 4'h5;
        edges(4);
        check("reset_digit", {4'd0, digit}, 8'h00);
        check("reset_anodes", {6'd0, anode1_n, anode2_n}, 8'h03);

        // Normal sequence with a mid-slot switch1 change and an early switch2 change.
        reset = 1'b0;
        edges(23);
        switch1 = 4'h3;
        edges(4);
        switch2 = 4'hC;
        edges(2);
        check("mid_slot_hold", {4'd0, digit}, 8'h0A);
        edges(1);
        check("sync_early_capture", {4'd0, digit}, 8'h0C);
        edges(10);
        check("mid_slot_next_show", {4'd0, digit}, 8'h03);

        // switch2 change one edge too late for the edge-30 capture.
        reset   = 1'b1;
        switch1 = 4'hA;
        switch2 = 4'h5;
        edges(2);
        reset = 1'b0;
        edges(28);
        switch2 = 4'hC;
        edges(2);
        check("sync_late_capture", {4'd0, digit}, 8'h05);

        // Asynchronous reset during SHOW2, then a clean restart.
        reset   = 1'b1;
        switch2 = 4'h5;
        edges(2);
        reset = 1'b0;
        edges(15);
        #1 reset = 1'b1;
        #1;
        check("async_reset_digit", {4'd0, digit}, 8'h00);
        check("async_reset_anodes", {6'd0, anode1_n, anode2_n}, 8'h03);
        edges(2);
        reset = 1'b0;
        edges(20);
        check("restart_digit", {4'd0, digit}, 8'h0A);
        edges(10);

        // Random soak with switch activity and occasional reset pulses.
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 3) == 0) switch1 = 4'($urandom);
            if ($urandom_range(0, 3) == 0) switch2 = 4'($urandom);
            if (!reset && $urandom_range(0, 299) == 0) begin
                #1 reset = 1'b1;
            end else if (reset && $urandom_range(0, 1) == 0) begin
                reset = 1'b0;
            end
            edges(1);
        end
        reset = 1'b0;
        edges(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
